// File: rtl/mmio_io_port_pkg.sv
// mmio_io_port shared definitions: register offsets and status bit positions.
// Imported by the top and the bench so both agree on the register map.
package mmio_io_port_pkg;

  localparam logic [1:0] MMIO_IN_DATA  = 2'd0;
  localparam logic [1:0] MMIO_IN_STAT  = 2'd1;
  localparam logic [1:0] MMIO_OUT_DATA = 2'd2;
  localparam logic [1:0] MMIO_OUT_STAT = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_IN_OVF  = 2;
  localparam int ST_COUNT   = 8;
  localparam int ST_BUSY    = 0;
  localparam int ST_OUT_OVF = 1;

endpackage

// File: rtl/mmio_io_port_if.sv
// mmio_io_port bus bundle: CPU load/store side plus external in/out side.
// master = environment (CPU + board), slave = the port.
interface mmio_io_port_if #(
  parameter int DW = 32
);
  logic [1:0]    cpu_addr;
  logic          cpu_re;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          ext_in_strobe;
  logic [DW-1:0] ext_in_data;
  logic          ext_out_ready;
  logic          ext_out_valid;
  logic [DW-1:0] ext_out_data;

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata,
    output ext_in_strobe, ext_in_data, ext_out_ready,
    input  cpu_rdata, ext_out_valid, ext_out_data
  );

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata,
    input  ext_in_strobe, ext_in_data, ext_out_ready,
    output cpu_rdata, ext_out_valid, ext_out_data
  );
endinterface

// File: rtl/mmio_io_port_fifo.sv
// mmio_io_port input FIFO: synchronous, registered storage, power-of-two depth.
// A push while full is taken only when a pop frees a slot that same cycle.
module mmio_io_port_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_io_port.sv
// mmio_io_port: MMIO responder, input strobe -> FIFO, CPU stores -> output handshake.
// Optional MMIO_IRQ_EN adds a registered irq output.
module mmio_io_port
  import mmio_io_port_pkg::*;
#(
  parameter int DW       = 32,
  parameter int IN_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MMIO_IRQ_EN
  output logic          irq,
`endif
  mmio_io_port_if.slave bus
);
  localparam int CW = $clog2(IN_DEPTH) + 1;

  logic          strobe_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [DW-1:0] fifo_rdata;
  logic          in_ovf;
  logic          out_ovf;
  logic          wr_in_stat;
  logic          wr_out;
  logic          wr_out_stat;
  logic          xfer;
  logic          out_take;
  logic [DW-1:0] in_stat;
  logic [DW-1:0] out_stat;
  logic [DW-1:0] rd_mux;

  assign push = bus.ext_in_strobe && !strobe_q;
  assign pop  = bus.cpu_re && (bus.cpu_addr == MMIO_IN_DATA) && !empty;

  assign wr_in_stat  = bus.cpu_we && (bus.cpu_addr == MMIO_IN_STAT);
  assign wr_out      = bus.cpu_we && (bus.cpu_addr == MMIO_OUT_DATA);
  assign wr_out_stat = bus.cpu_we && (bus.cpu_addr == MMIO_OUT_STAT);
  assign xfer        = bus.ext_out_valid && bus.ext_out_ready;
  // a completing transfer frees the register for a same-cycle store
  assign out_take    = wr_out && (!bus.ext_out_valid || xfer);

  mmio_io_port_fifo #(
    .DW    (DW),
    .DEPTH (IN_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.ext_in_data),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    in_stat                 = '0;
    in_stat[ST_EMPTY]       = empty;
    in_stat[ST_FULL]        = full;
    in_stat[ST_IN_OVF]      = in_ovf;
    in_stat[ST_COUNT +: CW] = count;
    out_stat                = '0;
    out_stat[ST_BUSY]       = bus.ext_out_valid;
    out_stat[ST_OUT_OVF]    = out_ovf;
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.cpu_addr)
      MMIO_IN_DATA:  rd_mux = empty ? '0 : fifo_rdata;
      MMIO_IN_STAT:  rd_mux = in_stat;
      MMIO_OUT_DATA: rd_mux = bus.ext_out_data;
      MMIO_OUT_STAT: rd_mux = out_stat;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q          <= 1'b0;
      in_ovf            <= 1'b0;
      out_ovf           <= 1'b0;
      bus.ext_out_valid <= 1'b0;
      bus.ext_out_data  <= '0;
      bus.cpu_rdata     <= '0;
    end else begin
      strobe_q <= bus.ext_in_strobe;
      if (wr_in_stat)                in_ovf <= 1'b0;
      else if (push && full && !pop) in_ovf <= 1'b1;
      if (wr_out_stat)               out_ovf <= 1'b0;
      else if (wr_out && !out_take)  out_ovf <= 1'b1;
      if (out_take) begin
        bus.ext_out_data  <= bus.cpu_wdata;
        bus.ext_out_valid <= 1'b1;
      end else if (xfer) begin
        bus.ext_out_valid <= 1'b0;
      end
      if (bus.cpu_re) bus.cpu_rdata <= rd_mux;
    end
  end

`ifdef MMIO_IRQ_EN
  logic out_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_done <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_out_stat) out_done <= 1'b0;
      else if (xfer)   out_done <= 1'b1;
      irq <= !empty || out_done;
    end
  end
`endif
endmodule

// File: tb/tb_mmio_io_port.sv
// tb_mmio_io_port: directed scenarios then random traffic against a queue model.
// Expected reads and output words go to queues, a monitor pops and compares.
module tb_mmio_io_port;
  import mmio_io_port_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_io_port_if #(.DW(DW)) bus ();

`ifdef MMIO_IRQ_EN
  logic irq;
  mmio_io_port #(.DW(DW), .IN_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .irq (irq),
    .bus (bus)
  );
`else
  mmio_io_port #(.DW(DW), .IN_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rdq[$];
  logic [31:0] outq[$];
  logic [31:0] fq[$];
  bit          m_prev  = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_oovf  = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;

  bit          s_strobe = 1'b0;
  bit          s_ready  = 1'b0;
  logic [31:0] s_sdata  = '0;
  bit          mon_rd;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  function automatic void model_reset();
    fq.delete();
    outq.delete();
    m_prev  = 1'b0;
    m_ovf   = 1'b0;
    m_oovf  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endfunction

  function automatic void model_step(bit re, bit we, logic [1:0] a,
                                     logic [31:0] wd);
    bit push, pop, full, xfer;
    logic [31:0] st;
    push   = s_strobe && !m_prev;
    m_prev = s_strobe;
    full   = (fq.size() == DEPTH);
    if (re) begin
      case (a)
        2'd0: begin
          if (fq.size() > 0) st = fq[0];
          else st = 32'h0;
        end
        2'd1: st = 32'(fq.size()) * 256 + (m_ovf ? 4 : 0)
                 + (full ? 2 : 0) + (fq.size() == 0 ? 1 : 0);
        2'd2: st = m_data;
        default: st = (m_oovf ? 2 : 0) + (m_valid ? 1 : 0);
      endcase
      rdq.push_back(st);
    end
    pop  = re && a == 2'd0 && fq.size() > 0;
    xfer = m_valid && s_ready;
    if (pop) void'(fq.pop_front());
    if (push) begin
      if (!full || pop) fq.push_back(s_sdata);
      else m_ovf = 1'b1;
    end
    if (we && a == 2'd1) m_ovf = 1'b0;
    if (we && a == 2'd2) begin
      if (!m_valid || xfer) begin
        m_data  = wd;
        m_valid = 1'b1;
        outq.push_back(wd);
      end else begin
        m_oovf = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (we && a == 2'd3) m_oovf = 1'b0;
  endfunction

  task automatic tick(bit re, bit we, logic [1:0] a, logic [31:0] wd);
    @(negedge clk);
    rst               = 1'b0;
    bus.cpu_re        = re;
    bus.cpu_we        = we;
    bus.cpu_addr      = a;
    bus.cpu_wdata     = wd;
    bus.ext_in_strobe = s_strobe;
    bus.ext_in_data   = s_sdata;
    bus.ext_out_ready = s_ready;
    model_step(re, we, a, wd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b1;
    s_strobe          = 1'b0;
    s_ready           = 1'b0;
    bus.cpu_re        = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 2'd0;
    bus.cpu_wdata     = '0;
    bus.ext_in_strobe = 1'b0;
    bus.ext_in_data   = '0;
    bus.ext_out_ready = 1'b0;
    model_reset();
  endtask

  task automatic pulse(logic [31:0] d);
    s_strobe = 1'b1;
    s_sdata  = d;
    tick(1'b0, 1'b0, 2'd0, '0);
    s_strobe = 1'b0;
    tick(1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic rd_expect(logic [1:0] a, logic [31:0] exp, string nm);
    tick(1'b1, 1'b0, a, '0);
    tick(1'b0, 1'b0, 2'd0, '0);
    chk(nm, bus.cpu_rdata, exp);
  endtask

  always @(posedge clk) begin
    mon_rd = bus.cpu_re && !rst;
    if (bus.ext_out_valid && bus.ext_out_ready && !rst) begin
      if (outq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_xfer: got %h want no transfer", bus.ext_out_data);
      end else begin
        chk("out_xfer", bus.ext_out_data, outq.pop_front());
      end
    end
    #1;
    if (mon_rd) begin
      if (rdq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdata: got %h want no read", bus.cpu_rdata);
      end else begin
        chk("rdata", bus.cpu_rdata, rdq.pop_front());
      end
    end
    chk("out_valid", 32'(bus.ext_out_valid), 32'(m_valid));
  end

  initial begin
    do_reset();
    tick(1'b0, 1'b0, 2'd0, '0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_odata", bus.ext_out_data, 32'h0);

    // single clean edge
    pulse(32'h1);
    rd_expect(MMIO_IN_STAT, 32'h100, "t1_stat");
    rd_expect(MMIO_IN_DATA, 32'h1, "t1_data");
    rd_expect(MMIO_IN_DATA, 32'h0, "empty_read");

    // level held high pushes once
    s_strobe = 1'b1;
    s_sdata  = 32'hA;
    repeat (5) tick(1'b0, 1'b0, 2'd0, '0);
    s_strobe = 1'b0;
    rd_expect(MMIO_IN_STAT, 32'h100, "t2_stat");
    rd_expect(MMIO_IN_DATA, 32'hA, "t2_data");

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) pulse(32'h11 + 32'(i));
    rd_expect(MMIO_IN_STAT, 32'h406, "t3_stat");
    for (int i = 0; i < DEPTH; i++)
      rd_expect(MMIO_IN_DATA, 32'h11 + 32'(i), "t3_data");
    tick(1'b0, 1'b1, MMIO_IN_STAT, 32'hFFFF_FFFF);
    rd_expect(MMIO_IN_STAT, 32'h001, "t3_clr");

    // output busy / drop / handshake
    s_ready = 1'b0;
    tick(1'b0, 1'b1, MMIO_OUT_DATA, 32'h5);
    tick(1'b0, 1'b0, 2'd0, '0);
    chk("t4_valid", 32'(bus.ext_out_valid), 32'h1);
    chk("t4_data", bus.ext_out_data, 32'h5);
    tick(1'b0, 1'b1, MMIO_OUT_DATA, 32'h8);
    rd_expect(MMIO_OUT_STAT, 32'h3, "t4_ostat");
    s_ready = 1'b1;
    tick(1'b0, 1'b0, 2'd0, '0);
    tick(1'b0, 1'b0, 2'd0, '0);
    chk("t4_done", 32'(bus.ext_out_valid), 32'h0);
    chk("t4_hold", bus.ext_out_data, 32'h5);
    tick(1'b0, 1'b1, MMIO_OUT_STAT, '0);
    rd_expect(MMIO_OUT_STAT, 32'h0, "t4_oclr");
    s_ready = 1'b0;

    // push and pop in the same cycle
    pulse(32'h21);
    pulse(32'h22);
    s_strobe = 1'b1;
    s_sdata  = 32'h23;
    tick(1'b1, 1'b0, MMIO_IN_DATA, '0);
    s_strobe = 1'b0;
    rd_expect(MMIO_IN_STAT, 32'h200, "t5_stat");
    rd_expect(MMIO_IN_DATA, 32'h22, "t5_d0");
    rd_expect(MMIO_IN_DATA, 32'h23, "t5_d1");

    // reset mid-operation
    for (int i = 0; i < 3; i++) pulse(32'h30 + 32'(i));
    tick(1'b0, 1'b1, MMIO_OUT_DATA, 32'h77);
    rd_expect(MMIO_IN_STAT, 32'h300, "t6_pre");
    do_reset();
    tick(1'b0, 1'b0, 2'd0, '0);
    chk("t6_valid", 32'(bus.ext_out_valid), 32'h0);
    chk("t6_rdata", bus.cpu_rdata, 32'h0);
    rd_expect(MMIO_IN_STAT, 32'h001, "t6_stat");

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end
      s_strobe = ($urandom_range(0, 1) == 1);
      s_sdata  = $urandom;
      s_ready  = ($urandom_range(0, 2) == 0);
      tick(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), $urandom);
    end

    s_strobe = 1'b0;
    s_ready  = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 2'd0, '0);
    chk("rdq_drain", 32'(rdq.size()), 32'h0);
    chk("outq_drain", 32'(outq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
